// File: rtl/pa_clic_arb_scan_pkg.sv
// Shared CLIC arbiter definitions: FSM encoding, key width, default sizing and
// the candidate record with its priority compare used by every arbitration stage.
package pa_clic_arb_scan_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } arb_state_e;

  localparam int KEY_WIDTH   = 9;
  localparam int IDX_WIDTH   = 12;
  localparam int DEF_INT_NUM = 64;
  localparam int DEF_GRP     = 8;

  typedef struct packed {
    logic                 vld;
    logic [KEY_WIDTH-1:0] key;  // {mode, clicintctl}
    logic [7:0]           il;
    logic                 hv;
    logic [IDX_WIDTH-1:0] idx;
  } arb_cand_t;

  // True when a should displace b: valid, higher key, or equal key and lower ID.
  function automatic logic cand_beats(input arb_cand_t a, input arb_cand_t b);
    if (!a.vld) return 1'b0;
    if (!b.vld) return 1'b1;
    if (a.key != b.key) return (a.key > b.key);
    return (a.idx < b.idx);
  endfunction

  function automatic arb_cand_t cand_merge(input arb_cand_t a, input arb_cand_t b);
    return cand_beats(b, a) ? b : a;
  endfunction

endpackage

// File: rtl/pa_clic_arb_scan_grp_cmp.sv
// Combinational GRP-input tournament tree; ties resolve to the lower source ID.
module pa_clic_arb_grp_cmp
  import pa_clic_arb_scan_pkg::*;
#(
  parameter int GRP = DEF_GRP
) (
  input  arb_cand_t cand_i [GRP],
  output arb_cand_t win_o
);

  localparam int NODES = 2 * GRP - 1;

  arb_cand_t node [NODES];

  // NOTE: blocking assignments in always_comb; each tree level reads values
  // written earlier in the same pass, which non-blocking would not provide.
  always_comb begin
    for (int i = 0; i < NODES; i++) node[i] = '0;
    for (int i = 0; i < GRP; i++) node[GRP-1+i] = cand_i[i];
    for (int n = GRP - 2; n >= 0; n--) node[n] = cand_merge(node[2*n+1], node[2*n+2]);
  end

  assign win_o = node[0];

endmodule

// File: rtl/pa_clic_arb_scan.sv
// Time-multiplexed CLIC arbiter: scans one GRP-wide group per cycle, keeps a
// running best and publishes the winner of each full sweep.
module pa_clic_arb_scan
  import pa_clic_arb_scan_pkg::*;
#(
  parameter int INT_NUM  = DEF_INT_NUM,
  parameter int GRP      = DEF_GRP,
  parameter int ID_WIDTH = 12
) (
  input  logic                  clicreg_clk,
  input  logic                  cpurst_b,
  input  logic                  arb_en,
  input  logic                  busif_arb_cfg_chg,
  input  logic [INT_NUM-1:0]    kid_arb_int_pend,
  input  logic [INT_NUM-1:0]    kid_arb_int_en,
  input  logic [INT_NUM-1:0]    kid_arb_int_mode,
  input  logic [INT_NUM-1:0]    kid_arb_int_hv,
  input  logic [8*INT_NUM-1:0]  kid_arb_int_ctl,
  input  logic [7:0]            ctrl_arb_lvl_mask,
  output logic                  arb_ctrl_int_req_raw,
  output logic [ID_WIDTH-1:0]   arb_ctrl_int_id,
  output logic [7:0]            arb_ctrl_int_il,
  output logic                  arb_ctrl_int_mode,
  output logic                  arb_ctrl_int_hv,
  output logic                  arb_sweep_done
);

  localparam int NGRP = INT_NUM / GRP;
  localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int SW   = (INT_NUM > 1) ? $clog2(INT_NUM) : 1;

  arb_state_e           state_q, state_d;
  logic [GW-1:0]        grp_idx_q, grp_idx_d;
  arb_cand_t            best_q, best_d;
  logic                 pub_vld_q, pub_vld_d;
  logic [IDX_WIDTH-1:0] pub_id_q, pub_id_d;
  logic [7:0]           pub_il_q, pub_il_d;
  logic                 pub_mode_q, pub_mode_d;
  logic                 pub_hv_q, pub_hv_d;

  arb_cand_t grp_cand [GRP];
  arb_cand_t grp_win;
  arb_cand_t merged;
  logic      last_grp;

  // Gather the group currently selected by grp_idx_q.
  for (genvar g = 0; g < GRP; g++) begin : g_gather
    logic [IDX_WIDTH-1:0] src;
    logic [SW-1:0]        sel;
    logic [7:0]           ctl;

    assign src = IDX_WIDTH'(grp_idx_q) * IDX_WIDTH'(GRP) + IDX_WIDTH'(g);
    assign sel = src[SW-1:0];
    assign ctl = kid_arb_int_ctl[{sel, 3'b000} +: 8];

    assign grp_cand[g] = '{
      vld: kid_arb_int_pend[sel] & kid_arb_int_en[sel],
      key: {kid_arb_int_mode[sel], ctl},
      il:  (ctl & ctrl_arb_lvl_mask) | ~ctrl_arb_lvl_mask,
      hv:  kid_arb_int_hv[sel],
      idx: src
    };
  end

  pa_clic_arb_grp_cmp #(
    .GRP(GRP)
  ) u_grp_cmp (
    .cand_i(grp_cand),
    .win_o (grp_win)
  );

  // Earlier groups hold lower IDs, so the running best sits on the tie-winning side.
  assign merged   = cand_merge(best_q, grp_win);
  assign last_grp = (grp_idx_q == GW'(NGRP - 1));

  // NOTE: every next-state signal takes its hold value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    grp_idx_d      = grp_idx_q;
    best_d         = best_q;
    pub_vld_d      = pub_vld_q;
    pub_id_d       = pub_id_q;
    pub_il_d       = pub_il_q;
    pub_mode_d     = pub_mode_q;
    pub_hv_d       = pub_hv_q;
    arb_sweep_done = 1'b0;

    case (state_q)
      ST_IDLE: begin
        grp_idx_d  = '0;
        best_d     = '0;
        pub_vld_d  = 1'b0;
        pub_id_d   = '0;
        pub_il_d   = '0;
        pub_mode_d = 1'b0;
        pub_hv_d   = 1'b0;
        if (arb_en) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (!arb_en) begin
          state_d    = ST_IDLE;
          grp_idx_d  = '0;
          best_d     = '0;
          pub_vld_d  = 1'b0;
          pub_id_d   = '0;
          pub_il_d   = '0;
          pub_mode_d = 1'b0;
          pub_hv_d   = 1'b0;
        end else if (busif_arb_cfg_chg) begin
          // Restart the sweep; published winner stays as is.
          grp_idx_d = '0;
          best_d    = '0;
        end else if (last_grp) begin
          pub_vld_d      = merged.vld;
          pub_id_d       = merged.vld ? merged.idx : '0;
          pub_il_d       = merged.vld ? merged.il : '0;
          pub_mode_d     = merged.vld & merged.key[KEY_WIDTH-1];
          pub_hv_d       = merged.vld & merged.hv;
          arb_sweep_done = 1'b1;
          best_d         = '0;
          grp_idx_d      = '0;
        end else begin
          best_d    = merged;
          grp_idx_d = grp_idx_q + GW'(1);
        end
      end
    endcase
  end

  // NOTE: non-blocking assignments for all state so every register samples
  // the pre-edge value of the others.
  always_ff @(posedge clicreg_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q    <= ST_IDLE;
      grp_idx_q  <= '0;
      best_q     <= '0;
      pub_vld_q  <= 1'b0;
      pub_id_q   <= '0;
      pub_il_q   <= '0;
      pub_mode_q <= 1'b0;
      pub_hv_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      grp_idx_q  <= grp_idx_d;
      best_q     <= best_d;
      pub_vld_q  <= pub_vld_d;
      pub_id_q   <= pub_id_d;
      pub_il_q   <= pub_il_d;
      pub_mode_q <= pub_mode_d;
      pub_hv_q   <= pub_hv_d;
    end
  end

  // Request is re-qualified against live pend/en so a dropped source never requests.
  always_comb begin
    arb_ctrl_int_req_raw = pub_vld_q
                         & kid_arb_int_pend[pub_id_q[SW-1:0]]
                         & kid_arb_int_en[pub_id_q[SW-1:0]];
  end

  assign arb_ctrl_int_id   = ID_WIDTH'(pub_id_q);
  assign arb_ctrl_int_il   = pub_il_q;
  assign arb_ctrl_int_mode = pub_mode_q;
  assign arb_ctrl_int_hv   = pub_hv_q;

endmodule

// File: tb/tb_pa_clic_arb_scan.sv
// Directed bench for pa_clic_arb_scan at INT_NUM=64, GRP=8 (sweep of 8 cycles).
module tb_pa_clic_arb_scan;

  localparam int INT_NUM  = 64;
  localparam int GRP      = 8;
  localparam int ID_WIDTH = 12;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 arb_en;
  logic                 cfg_chg;
  logic [INT_NUM-1:0]   pend, en, mode, hv;
  logic [8*INT_NUM-1:0] ctl;
  logic [7:0]           lvl_mask;
  logic                 req_raw;
  logic [ID_WIDTH-1:0]  int_id;
  logic [7:0]           int_il;
  logic                 int_mode;
  logic                 int_hv;
  logic                 done;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pa_clic_arb_scan #(
    .INT_NUM (INT_NUM),
    .GRP     (GRP),
    .ID_WIDTH(ID_WIDTH)
  ) dut (
    .clicreg_clk         (clk),
    .cpurst_b            (rst_n),
    .arb_en              (arb_en),
    .busif_arb_cfg_chg   (cfg_chg),
    .kid_arb_int_pend    (pend),
    .kid_arb_int_en      (en),
    .kid_arb_int_mode    (mode),
    .kid_arb_int_hv      (hv),
    .kid_arb_int_ctl     (ctl),
    .ctrl_arb_lvl_mask   (lvl_mask),
    .arb_ctrl_int_req_raw(req_raw),
    .arb_ctrl_int_id     (int_id),
    .arb_ctrl_int_il     (int_il),
    .arb_ctrl_int_mode   (int_mode),
    .arb_ctrl_int_hv     (int_hv),
    .arb_sweep_done      (done)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_out(input string tag, input int id, input int il,
                           input int md, input int h, input int req);
    check($sformatf("%s.id", tag),   int'(int_id),   id);
    check($sformatf("%s.il", tag),   int'(int_il),   il);
    check($sformatf("%s.mode", tag), int'(int_mode), md);
    check($sformatf("%s.hv", tag),   int'(int_hv),   h);
    check($sformatf("%s.req", tag),  int'(req_raw),  req);
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    step();
    while (!done && n < 40) begin
      step();
      n++;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  // Lands in the cycle right after a publishing edge.
  task automatic next_publish();
    wait_done();
    step();
  endtask

  task automatic set_src(input int k, input bit p, input bit e, input bit m,
                         input bit h, input logic [7:0] c);
    pend[k]        = p;
    en[k]          = e;
    mode[k]        = m;
    hv[k]          = h;
    ctl[8*k +: 8]  = c;
  endtask

  initial begin
    arb_en   = 1'b0;
    cfg_chg  = 1'b0;
    pend     = '0;
    en       = '0;
    mode     = '0;
    hv       = '0;
    ctl      = '0;
    lvl_mask = 8'hFF;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_out("rst", 0, 0, 0, 0, 0);
    check("rst.done", int'(done), 0);
    #2 rst_n = 1'b1;
    step();
    check("idle.done", int'(done), 0);

    // No pending: done on every 8th SCAN cycle, outputs stay zero
    arb_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("t1.done%0d", i), int'(done), int'(i == 8));
    end
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 1) check_out("t1.empty", 0, 0, 0, 0, 0);
      check($sformatf("t1.done2_%0d", i), int'(done), int'(i == 8));
    end

    // Higher ctl wins across groups; level masking
    set_src(5, 1, 1, 1, 0, 8'h40);
    set_src(60, 1, 1, 1, 1, 8'h80);
    next_publish();
    next_publish();
    check_out("t2", 60, 8'h80, 1, 1, 1);
    lvl_mask = 8'hE0;
    next_publish();
    next_publish();
    check_out("t2m", 60, 8'h9F, 1, 1, 1);

    // Winner drops: request falls immediately, runner-up next sweep
    pend[60] = 1'b0;
    #1;
    check("t3.req_now", int'(req_raw), 0);
    check("t3.id_held", int'(int_id), 60);
    next_publish();
    check_out("t3", 5, 8'h5F, 1, 0, 1);

    // Ties go to lower ID; mode dominates ctl
    pend = '0; en = '0; mode = '0; hv = '0; ctl = '0;
    lvl_mask = 8'hFF;
    set_src(3, 1, 1, 1, 0, 8'hC0);
    set_src(40, 1, 1, 1, 0, 8'hC0);
    next_publish();
    next_publish();
    check_out("t4tie", 3, 8'hC0, 1, 0, 1);
    set_src(3, 1, 1, 1, 0, 8'h00);
    set_src(40, 1, 1, 0, 0, 8'hFF);
    next_publish();
    next_publish();
    check_out("t4mode", 3, 8'h00, 1, 0, 1);
    set_src(17, 1, 1, 1, 0, 8'h55);
    set_src(18, 1, 1, 1, 1, 8'h55);
    next_publish();
    next_publish();
    check_out("t4grp", 17, 8'h55, 1, 0, 1);

    // cfg_chg on the last group: no publish, restart, publish 8 cycles later
    set_src(40, 1, 1, 1, 0, 8'hFF);
    repeat (7) step();
    check("t5.done_pre", int'(done), 1);
    cfg_chg = 1'b1;
    #1;
    check("t5.done_cfg", int'(done), 0);
    step();
    cfg_chg = 1'b0;
    check("t5.id_held", int'(int_id), 17);
    check("t5.done0", int'(done), 0);
    for (int i = 1; i <= 7; i++) begin
      step();
      check($sformatf("t5.done%0d", i), int'(done), int'(i == 7));
    end
    step();
    check_out("t5", 40, 8'hFF, 1, 0, 1);

    // arb_en dropped at group 4, then re-enabled
    repeat (4) step();
    arb_en = 1'b0;
    step();
    check_out("t6.idle", 0, 0, 0, 0, 0);
    check("t6.done", int'(done), 0);
    step();
    check("t6.id_idle2", int'(int_id), 0);
    arb_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("t6.done%0d", i), int'(done), int'(i == 8));
    end
    step();
    check_out("t6.re", 40, 8'hFF, 1, 0, 1);

    // Asynchronous reset mid-sweep
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    check_out("t7.rst", 0, 0, 0, 0, 0);
    check("t7.done", int'(done), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
